// File: rtl/eth_rx_hdr_parse_if.sv
// rtl/eth_rx_hdr_parse_if.sv - payload byte stream leaving the Ethernet header parser
//
// Signals (master = parser, slave = application consumer):
//   Data   8   payload byte
//   Valid  1   Data is valid this cycle
//   Sop    1   first payload byte of a frame (qualified by Valid)
//   Eop    1   last payload byte of a frame (qualified by Valid)
//   Abort  1   one-cycle pulse: current payload truncated, discard it
//   Len    pCNT_WIDTH  payload byte count, valid with Eop
interface eth_rx_hdr_parse_if #(
  parameter int pCNT_WIDTH = 16
);
  logic [7:0]            Data;
  logic                  Valid;
  logic                  Sop;
  logic                  Eop;
  logic                  Abort;
  logic [pCNT_WIDTH-1:0] Len;

  modport master (output Data, Valid, Sop, Eop, Abort, Len);
  modport slave  (input  Data, Valid, Sop, Eop, Abort, Len);
endinterface

// File: rtl/eth_rx_hdr_parse.sv
// rtl/eth_rx_hdr_parse.sv - Ethernet header parser, destination MAC filter and payload forwarder
//
// Ports:
//   Clk, Rst          clock and synchronous active-high reset
//   Recv_Byte         upstream word {SOP, EOP, data[7:0]}
//   Recv_Byte_Rdy     Recv_Byte valid this cycle (no backpressure)
//   Local_Mac         station address, first wire byte in bits 47:40
//   Promisc           accept any destination
//   Dst_Mac, Src_Mac, Eth_Type  captured header fields
//   Hdr_Valid         one-cycle pulse: fields valid and frame accepted
//   Pld               payload stream (eth_rx_hdr_parse_if.master)
//   Drop_Cnt          frames rejected by the filter (saturating)
//   Runt_Cnt          frames ending inside the header (saturating)
//   Err_Cnt           SOP seen mid-frame (saturating)
module eth_rx_hdr_parse #(
  parameter int pCNT_WIDTH = 16,
  parameter int pHDR_BYTES = 14
) (
  input  logic                  Clk,
  input  logic                  Rst,
  input  logic [9:0]            Recv_Byte,
  input  logic                  Recv_Byte_Rdy,
  input  logic [47:0]           Local_Mac,
  input  logic                  Promisc,
  output logic [47:0]           Dst_Mac,
  output logic [47:0]           Src_Mac,
  output logic [15:0]           Eth_Type,
  output logic                  Hdr_Valid,
  eth_rx_hdr_parse_if.master    Pld,
  output logic [pCNT_WIDTH-1:0] Drop_Cnt,
  output logic [pCNT_WIDTH-1:0] Runt_Cnt,
  output logic [pCNT_WIDTH-1:0] Err_Cnt
);

  typedef enum logic [1:0] {IDLE, HDR, PLD, DROP} tState;

  localparam logic [3:0]  cLastIdx = 4'(pHDR_BYTES - 1);
  localparam logic [47:0] cBcast   = '1;

  tState                 state;
  logic [3:0]            hdrIdx;
  logic [pCNT_WIDTH-1:0] pldCnt;

  logic       inSop;
  logic       inEop;
  logic [7:0] inData;
  logic       dstAccept;

  assign inSop  = Recv_Byte[9];
  assign inEop  = Recv_Byte[8];
  assign inData = Recv_Byte[7:0];

  // Dst_Mac is complete once header byte 5 is in, so it is stable when
  // byte 13 is being evaluated.
  assign dstAccept = Promisc || (Dst_Mac == Local_Mac) || (Dst_Mac == cBcast);

  function automatic logic [pCNT_WIDTH-1:0] satInc(input logic [pCNT_WIDTH-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state     <= IDLE;
      hdrIdx    <= '0;
      pldCnt    <= '0;
      Dst_Mac   <= '0;
      Src_Mac   <= '0;
      Eth_Type  <= '0;
      Hdr_Valid <= 1'b0;
      Pld.Data  <= '0;
      Pld.Valid <= 1'b0;
      Pld.Sop   <= 1'b0;
      Pld.Eop   <= 1'b0;
      Pld.Abort <= 1'b0;
      Pld.Len   <= '0;
      Drop_Cnt  <= '0;
      Runt_Cnt  <= '0;
      Err_Cnt   <= '0;
    end else begin
      Hdr_Valid <= 1'b0;
      Pld.Valid <= 1'b0;
      Pld.Sop   <= 1'b0;
      Pld.Eop   <= 1'b0;
      Pld.Abort <= 1'b0;

      if (Recv_Byte_Rdy) begin
        if (inSop) begin
          // SOP always restarts header capture, whatever the state.
          if (state != IDLE) Err_Cnt <= satInc(Err_Cnt);
          if (state == PLD) Pld.Abort <= 1'b1;
          Dst_Mac <= {Dst_Mac[39:0], inData};
          if (inEop) begin
            Runt_Cnt <= satInc(Runt_Cnt);
            state    <= IDLE;
          end else begin
            hdrIdx <= 4'd1;
            state  <= HDR;
          end
        end else begin
          case (state)
            IDLE: ;
            HDR: begin
              if (hdrIdx < 4'd6)       Dst_Mac  <= {Dst_Mac[39:0], inData};
              else if (hdrIdx < 4'd12) Src_Mac  <= {Src_Mac[39:0], inData};
              else                     Eth_Type <= {Eth_Type[7:0], inData};

              if (inEop) begin
                Runt_Cnt <= satInc(Runt_Cnt);
                state    <= IDLE;
              end else if (hdrIdx == cLastIdx) begin
                if (dstAccept) begin
                  Hdr_Valid <= 1'b1;
                  pldCnt    <= '0;
                  state     <= PLD;
                end else begin
                  Drop_Cnt <= satInc(Drop_Cnt);
                  state    <= DROP;
                end
              end else begin
                hdrIdx <= hdrIdx + 1'b1;
              end
            end
            PLD: begin
              Pld.Valid <= 1'b1;
              Pld.Data  <= inData;
              Pld.Sop   <= (pldCnt == '0);
              pldCnt    <= satInc(pldCnt);
              if (inEop) begin
                Pld.Eop <= 1'b1;
                Pld.Len <= satInc(pldCnt);
                state   <= IDLE;
              end
            end
            DROP: begin
              if (inEop) state <= IDLE;
            end
            default: state <= IDLE;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_eth_rx_hdr_parse.sv
// tb/tb_eth_rx_hdr_parse.sv - scoreboard testbench for eth_rx_hdr_parse
module tb_eth_rx_hdr_parse;

  logic        Clk = 1'b0;
  logic        Rst;
  logic [9:0]  Recv_Byte;
  logic        Recv_Byte_Rdy;
  logic [47:0] Local_Mac;
  logic        Promisc;
  logic [47:0] Dst_Mac;
  logic [47:0] Src_Mac;
  logic [15:0] Eth_Type;
  logic        Hdr_Valid;
  logic [15:0] Drop_Cnt;
  logic [15:0] Runt_Cnt;
  logic [15:0] Err_Cnt;

  eth_rx_hdr_parse_if #(.pCNT_WIDTH(16)) pld ();

  eth_rx_hdr_parse dut (
    .Clk           (Clk),
    .Rst           (Rst),
    .Recv_Byte     (Recv_Byte),
    .Recv_Byte_Rdy (Recv_Byte_Rdy),
    .Local_Mac     (Local_Mac),
    .Promisc       (Promisc),
    .Dst_Mac       (Dst_Mac),
    .Src_Mac       (Src_Mac),
    .Eth_Type      (Eth_Type),
    .Hdr_Valid     (Hdr_Valid),
    .Pld           (pld),
    .Drop_Cnt      (Drop_Cnt),
    .Runt_Cnt      (Runt_Cnt),
    .Err_Cnt       (Err_Cnt)
  );

  always #5 Clk = ~Clk;

  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] data;
    logic       sop;
    logic       eop;
    int         len;
    int         cyc;
  } tBeat;

  typedef struct {
    logic [47:0] dst;
    logic [47:0] src;
    logic [15:0] typ;
    int          cyc;
  } tHdr;

  tBeat beatQ[$];
  tHdr  hdrQ[$];
  int   abortQ[$];

  int nTests = 0;
  int nFail  = 0;

  // Frame-level reference model state
  bit open       = 1'b0;
  bit openInPld  = 1'b0;
  int expDrop    = 0;
  int expRunt    = 0;
  int expErr     = 0;

  logic [7:0] fb[$];

  localparam logic [47:0] cLocal = 48'h02_00_00_00_00_01;
  localparam logic [47:0] cSrc   = 48'h02_00_00_00_00_02;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nTests++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic driveWord(input logic sop, input logic eop, input logic [7:0] d, output int c);
    @(negedge Clk);
    Recv_Byte     = {sop, eop, d};
    Recv_Byte_Rdy = 1'b1;
    c             = cyc;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge Clk);
      Recv_Byte_Rdy = 1'b0;
    end
  endtask

  task automatic buildFrame(input logic [47:0] dst, input logic [47:0] src, input logic [15:0] typ,
                            input int plen, input int first, input bit rnd);
    fb = {};
    for (int i = 0; i < 6; i++) fb.push_back(dst[47-8*i -: 8]);
    for (int i = 0; i < 6; i++) fb.push_back(src[47-8*i -: 8]);
    fb.push_back(typ[15:8]);
    fb.push_back(typ[7:0]);
    for (int i = 0; i < plen; i++) fb.push_back(rnd ? 8'($urandom) : 8'(first + i));
  endtask

  // Sends a frame and records what the application side must see, derived
  // from the frame as a whole: header length 14, filter rule, payload = rest.
  task automatic sendFrame(input logic [7:0] b[$], input bit withSop, input bit withEop, input int gap);
    int          n;
    int          c;
    bit          hdrDone;
    bit          acc;
    logic [47:0] dst;
    logic [47:0] src;
    logic [15:0] typ;
    n       = b.size();
    hdrDone = (n > 14) || (n == 14 && !withEop);
    acc     = 1'b0;
    dst     = '0;
    src     = '0;
    typ     = '0;
    if (n >= 6)  dst = {b[0], b[1], b[2], b[3], b[4], b[5]};
    if (n >= 12) src = {b[6], b[7], b[8], b[9], b[10], b[11]};
    if (n >= 14) typ = {b[12], b[13]};
    if (withSop) begin
      if (open) expErr++;
      if (hdrDone) begin
        acc = Promisc || (dst == Local_Mac) || (dst == 48'hFFFF_FFFF_FFFF);
        if (!acc) expDrop++;
      end
      if (withEop && n <= 14) expRunt++;
    end
    for (int i = 0; i < n; i++) begin
      driveWord(withSop && i == 0, withEop && i == n - 1, b[i], c);
      if (withSop && i == 0 && openInPld) abortQ.push_back(c + 1);
      if (withSop && acc && i == 13) hdrQ.push_back('{dst, src, typ, c + 1});
      if (withSop && acc && i >= 14)
        beatQ.push_back('{b[i], i == 14, withEop && i == n - 1, n - 14, c + 1});
      if (i < n - 1) idle(gap);
    end
    if (withSop) begin
      open      = !withEop;
      openInPld = open && acc;
    end
  endtask

  task automatic doReset();
    @(negedge Clk);
    Rst           = 1'b1;
    Recv_Byte_Rdy = 1'b0;
    @(negedge Clk);
    Rst       = 1'b0;
    open      = 1'b0;
    openInPld = 1'b0;
    expDrop   = 0;
    expRunt   = 0;
    expErr    = 0;
  endtask

  task automatic checkCnts(input string tag);
    idle(3);
    chk({tag, "_drop_cnt"}, Drop_Cnt, expDrop);
    chk({tag, "_runt_cnt"}, Runt_Cnt, expRunt);
    chk({tag, "_err_cnt"},  Err_Cnt,  expErr);
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents an output.
  initial begin : monitor
    tBeat e;
    tHdr  h;
    forever begin
      @(negedge Clk);
      if (pld.Valid) begin
        chk("beat_expected", beatQ.size() > 0, 1'b1);
        if (beatQ.size() > 0) begin
          e = beatQ.pop_front();
          chk("beat_data",  pld.Data, e.data);
          chk("beat_sop",   pld.Sop,  e.sop);
          chk("beat_eop",   pld.Eop,  e.eop);
          chk("beat_cycle", cyc,      e.cyc);
          if (e.eop) chk("beat_len", pld.Len, e.len);
        end
      end
      if (Hdr_Valid) begin
        chk("hdr_expected", hdrQ.size() > 0, 1'b1);
        if (hdrQ.size() > 0) begin
          h = hdrQ.pop_front();
          chk("hdr_dst",   Dst_Mac,  h.dst);
          chk("hdr_src",   Src_Mac,  h.src);
          chk("hdr_type",  Eth_Type, h.typ);
          chk("hdr_cycle", cyc,      h.cyc);
        end
      end
      if (pld.Abort) begin
        chk("abort_expected", abortQ.size() > 0, 1'b1);
        if (abortQ.size() > 0) chk("abort_cycle", cyc, abortQ.pop_front());
      end
    end
  end

  initial begin : stim
    logic [7:0]  tmp[$];
    logic [47:0] dst;
    int          plen;
    int          n;
    int          r;
    bit          eopFlag;

    Rst           = 1'b1;
    Recv_Byte     = '0;
    Recv_Byte_Rdy = 1'b0;
    Local_Mac     = cLocal;
    Promisc       = 1'b0;
    repeat (3) @(negedge Clk);
    chk("rst_dst",      Dst_Mac,   48'h0);
    chk("rst_src",      Src_Mac,   48'h0);
    chk("rst_type",     Eth_Type,  16'h0);
    chk("rst_hdrvalid", Hdr_Valid, 1'b0);
    chk("rst_pldvalid", pld.Valid, 1'b0);
    chk("rst_len",      pld.Len,   16'h0);
    chk("rst_abort",    pld.Abort, 1'b0);
    Rst = 1'b0;
    checkCnts("rst");

    // Bytes without SOP after reset are ignored.
    buildFrame(cLocal, cSrc, 16'h0800, 4, 0, 1'b0);
    sendFrame(fb, 1'b0, 1'b1, 0);
    idle(2);

    // Unicast, 46-byte payload 0x00..0x2D.
    buildFrame(cLocal, cSrc, 16'hFFFF, 46, 0, 1'b0);
    sendFrame(fb, 1'b1, 1'b1, 0);
    checkCnts("unicast");

    // Broadcast, single payload byte.
    buildFrame(48'hFFFF_FFFF_FFFF, cSrc, 16'h0806, 1, 8'hA5, 1'b0);
    sendFrame(fb, 1'b1, 1'b1, 0);
    checkCnts("bcast");

    // Filter reject, then the same frame in promiscuous mode.
    buildFrame(48'h02_00_00_00_00_09, cSrc, 16'h0800, 8, 8'h10, 1'b0);
    sendFrame(fb, 1'b1, 1'b1, 0);
    checkCnts("drop");
    Promisc = 1'b1;
    sendFrame(fb, 1'b1, 1'b1, 0);
    checkCnts("promisc");
    Promisc = 1'b0;

    // Runts: EOP on byte 9, then EOP on byte 13; back-to-back.
    buildFrame(cLocal, cSrc, 16'h0800, 0, 0, 1'b0);
    tmp = fb[0:9];
    sendFrame(tmp, 1'b1, 1'b1, 0);
    sendFrame(fb, 1'b1, 1'b1, 0);
    // Single byte carrying SOP and EOP.
    tmp = fb[0:0];
    sendFrame(tmp, 1'b1, 1'b1, 0);
    checkCnts("runt");

    // Mid-frame SOP after 20 payload bytes.
    buildFrame(cLocal, cSrc, 16'h0800, 40, 8'h40, 1'b0);
    tmp = fb[0:33];
    sendFrame(tmp, 1'b1, 1'b0, 0);
    buildFrame(cLocal, cSrc, 16'h88B5, 4, 8'hC0, 1'b0);
    sendFrame(fb, 1'b1, 1'b1, 0);
    checkCnts("midsop");

    // Reset mid-payload, remaining bytes without SOP, then a normal frame; gaps of 3.
    buildFrame(cLocal, cSrc, 16'h0800, 30, 8'h60, 1'b0);
    tmp = fb[0:23];
    sendFrame(tmp, 1'b1, 1'b0, 3);
    doReset();
    chk("rst2_dst", Dst_Mac, 48'h0);
    tmp = fb[24:$];
    sendFrame(tmp, 1'b0, 1'b1, 3);
    checkCnts("rst2");
    buildFrame(cLocal, cSrc, 16'h86DD, 12, 8'h80, 1'b0);
    sendFrame(fb, 1'b1, 1'b1, 3);
    checkCnts("after_rst");

    // Randomized frames: mixed destinations, lengths, truncations and gaps.
    for (int k = 0; k < 40; k++) begin
      r = int'($urandom_range(0, 2));
      if (r == 0)      dst = cLocal;
      else if (r == 1) dst = 48'hFFFF_FFFF_FFFF;
      else             dst = {16'h0A00, 32'($urandom)};
      Promisc = ($urandom_range(0, 3) == 0);
      plen = int'($urandom_range(0, 30));
      buildFrame(dst, {16'h0200, 32'($urandom)}, 16'($urandom), plen, 0, 1'b1);
      n       = fb.size();
      eopFlag = 1'b1;
      r       = int'($urandom_range(0, 9));
      if (k < 39 && r == 0) begin
        n = int'($urandom_range(1, 13));
      end else if (k < 39 && r == 1) begin
        n       = int'($urandom_range(1, fb.size()));
        eopFlag = 1'b0;
      end
      tmp = fb[0:n-1];
      sendFrame(tmp, 1'b1, eopFlag, int'($urandom_range(0, 2)));
      idle(int'($urandom_range(0, 2)));
    end
    Promisc = 1'b0;
    checkCnts("random");

    idle(5);
    chk("beats_left",  beatQ.size(),  0);
    chk("hdrs_left",   hdrQ.size(),   0);
    chk("aborts_left", abortQ.size(), 0);

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule

// File: doc/eth_rx_hdr_parse.md
Name: eth_rx_hdr_parse

Overview:
- Sits directly downstream of the Ethernet RMII receive stage (eth_rx).
- Consumes its CRC-qualified byte stream (10-bit words: bit 9 = SOP, bit 8 = EOP, bits 7:0 = data) and parses the 14-byte Ethernet header (destination MAC, source MAC, EtherType).
- Applies a destination-MAC filter and forwards only the payload of accepted frames as a framed byte stream for the application layer.
- Keeps saturating statistics counters.

Parameters:
- pCNT_WIDTH, 16, width of statistics counters and payload length.
- pHDR_BYTES, 14, header length in bytes; fixed for this release, not to be overridden.

Ports:
- Clk  in  1  system clock; same domain as upstream RX output.
- Rst  in  1  synchronous, active-high reset.
- Recv_Byte  in  10  upstream word: {SOP, EOP, data[7:0]}.
- Recv_Byte_Rdy  in  1  Recv_Byte valid this cycle; no backpressure exists.
- Local_Mac  in  48  station address; byte 0 on the wire = bits 47:40.
- Promisc  in  1  1 = accept any destination.
- Dst_Mac  out  48  captured destination MAC.
- Src_Mac  out  48  captured source MAC.
- Eth_Type  out  16  captured EtherType; first wire byte = bits 15:8.
- Hdr_Valid  out  1  one-cycle pulse: header fields valid, frame accepted.
- Pld_Data  out  8  payload byte.
- Pld_Valid  out  1  Pld_Data valid.
- Pld_Sop  out  1  first payload byte of a frame (qualified by Pld_Valid).
- Pld_Eop  out  1  last payload byte of a frame (qualified by Pld_Valid).
- Pld_Abort  out  1  one-cycle pulse: current payload truncated, discard it.
- Pld_Len  out  16  payload byte count, valid with Pld_Eop.
- Drop_Cnt  out  16  frames rejected by the MAC filter.
- Runt_Cnt  out  16  frames ending at or before header byte 13.
- Err_Cnt  out  16  SOP received mid-frame.

Behaviour:
Reset:
- State = IDLE.
- All outputs 0, including captured fields and counters.
- Reset mid-frame discards the frame. No Pld_Abort pulse and no counter update.
- After reset, bytes are ignored until the next SOP.

Input rules:
- Only cycles with Recv_Byte_Rdy = 1 are processed. Idle cycles between bytes are allowed anywhere.

State machine:
- IDLE: byte with SOP=1 → capture as header byte 0, byte index = 1 → HDR. Bytes without SOP are ignored.
- HDR: shift bytes into Dst_Mac (idx 0-5), Src_Mac (6-11), Eth_Type (12-13), MSB first.
  - EOP on any header byte (idx ≤ 13): Runt_Cnt++ → IDLE. No Hdr_Valid.
  - idx 13 without EOP: evaluate the filter. Accept if Dst == Local_Mac, or Dst == FF:FF:FF:FF:FF:FF, or Promisc = 1.
  - Accept → PLD; Hdr_Valid pulses the next cycle with all fields stable.
  - Reject → DROP; Drop_Cnt++.
  - Fields hold their value until the next frame's header overwrites them.
- PLD: each byte is forwarded.
  - Pld_Valid / Pld_Data are registered, exactly 1 cycle after the input Rdy.
  - Pld_Sop on the first payload byte.
  - Byte with EOP: Pld_Eop = 1, Pld_Len = total payload bytes including this one → IDLE.
  - A single-byte payload asserts Pld_Sop and Pld_Eop together.
- DROP: consume bytes until EOP → IDLE. No outputs.

Boundary conditions:
- SOP while in HDR, PLD or DROP: Err_Cnt++, and the byte restarts header capture as byte 0 (state HDR).
  - If the state was PLD, Pld_Abort pulses on the cycle that byte would have been output; no Pld_Eop for the aborted frame.
- Simultaneous SOP+EOP on one byte is a runt: Runt_Cnt++ → IDLE.
- Pld_Len saturates at 0xFFFF.
- All counters saturate at 0xFFFF and never wrap.
- Upstream EOP always terminates a frame; no internal length limit.

Timing:
- Back-to-back frames (EOP followed by SOP on the next valid cycle) are handled with no dead cycle.
- Throughput: 1 byte per cycle sustained.

Test Plan:
- Unicast frame: Local_Mac 02:00:00:00:00:01, Dst matching, Src 02:00:00:00:00:02, Eth_Type 0xFFFF, 46 payload bytes 0x00..0x2D → Hdr_Valid once with the exact fields; 46 Pld_Valid beats with data 0x00..0x2D, Pld_Sop on 0x00, Pld_Eop on 0x2D, Pld_Len = 46; each beat 1 cycle after its input.
- Broadcast Dst FF:FF:FF:FF:FF:FF with Promisc = 0, 1-byte payload 0xA5 → single beat with Pld_Sop = Pld_Eop = 1, Pld_Len = 1.
- Dst 02:00:00:00:00:09 with Promisc = 0 → no Hdr_Valid, no Pld_Valid, Drop_Cnt = 1; repeated with Promisc = 1 → frame forwarded, Drop_Cnt unchanged.
- Runt: 10-byte frame with EOP on byte 9, then a 14-byte frame with EOP on byte 13 → Runt_Cnt = 2, no Hdr_Valid, no Pld_Valid.
- Mid-frame SOP: after 20 payload bytes of an accepted frame, a new SOP frame (valid unicast, 4 payload bytes) → Pld_Abort one pulse, Err_Cnt = 1, second frame delivered with Pld_Len = 4.
- Rst asserted mid-payload for 1 cycle, then the remaining bytes without SOP → no output, counters 0; next valid frame delivered normally. Gaps of 3 idle cycles between bytes do not change the results.
